// File: rtl/counter_timer_arbiter.sv
// Round-robin arbiter that lends one loadable down-counter to M timeout clients.
// The winner's value is loaded with a single trig pulse; the winner gets done when out_pulse arrives.
module counter_timer_arbiter #(
    parameter int N = 3,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M-1:0]     req,
    input  logic [M*N-1:0]   req_val,
    output logic [M-1:0]     grant,
    output logic [M-1:0]     done,
    output logic             err,
    output logic             busy,
    inout  wire  [N-1:0]     cnt_bus,
    output logic             cnt_we,
    output logic             cnt_trig,
    input  logic             cnt_pulse
);

    localparam int PW = (M > 1) ? $clog2(M) : 1;
    localparam logic [N-1:0] WDOG_LAST = {N{1'b1}};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state_reg;
    logic [M-1:0]    grant_reg;
    logic            err_reg;
    logic [PW-1:0]   rr_ptr_reg;
    logic [N-1:0]    val_reg;
    logic [N-1:0]    wdog_reg;

    logic [N-1:0]    vals [M];
    logic [PW-1:0]   winner;
    logic            any_req;
    logic            granted_req;
    logic            load_drive;

    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_vals
            assign vals[gi] = req_val[gi*N +: N];
        end
    endgenerate

    // Scan from the farthest offset down so the closest set bit at/after rr_ptr wins.
    always_comb begin
        winner = '0;
        for (int k = M - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_ptr_reg) + k) % M;
            if (req[idx]) begin
                winner = PW'(idx);
            end
        end
    end

    assign any_req     = |req;
    assign granted_req = |(req & grant_reg);

    // The bus is only ever driven during LOAD of a non-zero value.
    assign load_drive = (state_reg == LOAD) && (val_reg != '0);
    assign cnt_we     = ~load_drive;
    assign cnt_trig   = load_drive;
    assign cnt_bus    = load_drive ? val_reg : {N{1'bz}};

    assign grant = grant_reg;
    assign done  = (state_reg == DONE) ? grant_reg : '0;
    assign err   = err_reg;
    assign busy  = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            err_reg    <= 1'b0;
            rr_ptr_reg <= '0;
            val_reg    <= '0;
            wdog_reg   <= '0;
        end else begin
            err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    wdog_reg <= '0;
                    if (any_req) begin
                        val_reg    <= vals[winner];
                        grant_reg  <= M'(1) << winner;
                        rr_ptr_reg <= (winner == PW'(M - 1)) ? '0 : winner + 1'b1;
                        state_reg  <= LOAD;
                    end
                end
                LOAD: begin
                    wdog_reg  <= '0;
                    state_reg <= (val_reg != '0) ? RUN : DONE;
                end
                RUN: begin
                    if (cnt_pulse) begin
                        state_reg <= DONE;
                    end else if (!granted_req) begin
                        grant_reg <= '0;
                        state_reg <= IDLE;
                    end else if (wdog_reg == WDOG_LAST) begin
                        // This is the 2^N-th RUN cycle without a pulse.
                        err_reg   <= 1'b1;
                        grant_reg <= '0;
                        state_reg <= IDLE;
                    end else begin
                        wdog_reg <= wdog_reg + 1'b1;
                    end
                end
                DONE: begin
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    grant_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
